mii_rx_fcs_check: RTL and testbench

MII_RX_FCS_CHECK -- requirements
Module: mii_rx_fcs_check

---
 rtl/mii_rx_fcs_check.sv | 173 +++++++++++++++++
 tb/tb_mii_rx_fcs_check.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mii_rx_fcs_check.sv
// MII receive framer: nibble-to-byte assembly, preamble/SFD
// detection, CRC-32 FCS check and per-frame status reporting.
module mii_rx_fcs_check #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rxdv,
  input  logic [3:0]  rxd,
  input  logic        rxer,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sof,
  output logic        frame_done,
  output logic        frame_good,
  output logic        err_crc,
  output logic        err_align,
  output logic        err_len,
  output logic        err_rxer,
  output logic [10:0] frame_len
);

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } state_t;

  localparam logic [31:0] POLY    = 32'h04C11DB7;
  localparam logic [31:0] RESIDUE = 32'hC704DD7B;
  localparam logic [10:0] MIN_L   = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L   = 11'(MAX_LEN);
  localparam logic [10:0] CNT_MAX = 11'h7FF;

  state_t      state_q;
  logic [31:0] crc_q;
  logic [31:0] crc_d;
  logic        phase_q;
  logic [3:0]  lo_q;
  logic [10:0] cnt_q;
  logic        rxer_seen_q;
  logic        len_bad;
  logic        crc_bad;

  logic [7:0]  rx_data_q;
  logic        rx_valid_q;
  logic        rx_sof_q;
  logic        frame_done_q;
  logic        frame_good_q;
  logic        err_crc_q;
  logic        err_align_q;
  logic        err_len_q;
  logic        err_rxer_q;
  logic [10:0] frame_len_q;

  // Serial CRC over one nibble, wire-first bit (d[0]) shifted in first.
  function automatic logic [31:0] crc_nib(
    input logic [31:0] c,
    input logic [3:0]  d
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 4; i++) begin
      if (r[31] ^ d[i]) begin
        r = {r[30:0], 1'b0} ^ POLY;
      end else begin
        r = {r[30:0], 1'b0};
      end
    end
    return r;
  endfunction

  // Next CRC value and end-of-frame error terms.
  always_comb begin
    crc_d   = crc_nib(crc_q, rxd);
    crc_bad = (crc_q != RESIDUE);
    len_bad = (cnt_q < MIN_L) || (cnt_q > MAX_L);
  end

  // Receive FSM with registered byte stream and frame status.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      crc_q        <= '1;
      phase_q      <= 1'b0;
      lo_q         <= '0;
      cnt_q        <= '0;
      rxer_seen_q  <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_sof_q     <= 1'b0;
      frame_done_q <= 1'b0;
      frame_good_q <= 1'b0;
      err_crc_q    <= 1'b0;
      err_align_q  <= 1'b0;
      err_len_q    <= 1'b0;
      err_rxer_q   <= 1'b0;
      frame_len_q  <= '0;
    end else begin
      rx_valid_q   <= 1'b0;
      rx_sof_q     <= 1'b0;
      frame_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rxdv) begin
            state_q <= (rxd == 4'h5) ? PREAMBLE : DROP;
          end
        end
        PREAMBLE: begin
          if (!rxdv) begin
            state_q <= IDLE;
          end else if (rxd == 4'hD) begin
            state_q     <= DATA;
            crc_q       <= '1;
            phase_q     <= 1'b0;
            cnt_q       <= '0;
            rxer_seen_q <= 1'b0;
          end else if (rxd != 4'h5) begin
            state_q <= DROP;
          end
        end
        DATA: begin
          if (rxdv) begin
            crc_q   <= crc_d;
            phase_q <= ~phase_q;
            if (rxer) begin
              rxer_seen_q <= 1'b1;
            end
            if (!phase_q) begin
              lo_q <= rxd;
            end else begin
              rx_data_q  <= {rxd, lo_q};
              rx_valid_q <= 1'b1;
              rx_sof_q   <= (cnt_q == '0);
              if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 11'd1;
              end
            end
          end else begin
            state_q      <= IDLE;
            frame_done_q <= 1'b1;
            err_crc_q    <= crc_bad;
            err_align_q  <= phase_q;
            err_len_q    <= len_bad;
            err_rxer_q   <= rxer_seen_q;
            frame_good_q <= ~(crc_bad | phase_q | len_bad | rxer_seen_q);
            frame_len_q  <= cnt_q;
          end
        end
        DROP: begin
          if (!rxdv) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_sof     = rx_sof_q;
  assign frame_done = frame_done_q;
  assign frame_good = frame_good_q;
  assign err_crc    = err_crc_q;
  assign err_align  = err_align_q;
  assign err_len    = err_len_q;
  assign err_rxer   = err_rxer_q;
  assign frame_len  = frame_len_q;

endmodule

// File: tb/tb_mii_rx_fcs_check.sv
// Self-checking bench for mii_rx_fcs_check: random frames
// scored against a byte/nibble-level Ethernet FCS model.
module tb_mii_rx_fcs_check;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rxdv;
  logic [3:0]  rxd;
  logic        rxer;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_sof;
  logic        frame_done;
  logic        frame_good;
  logic        err_crc;
  logic        err_align;
  logic        err_len;
  logic        err_rxer;
  logic [10:0] frame_len;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0]  nib_q[$];
  logic [7:0]  got_q[$];
  logic [15:0] done_q[$];
  int          sof_cnt = 0;
  int          sof_pos = -1;
  int          rst_snap = 0;

  always #5 clk = ~clk;

  mii_rx_fcs_check #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxdv       (rxdv),
    .rxd        (rxd),
    .rxer       (rxer),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_sof     (rx_sof),
    .frame_done (frame_done),
    .frame_good (frame_good),
    .err_crc    (err_crc),
    .err_align  (err_align),
    .err_len    (err_len),
    .err_rxer   (err_rxer),
    .frame_len  (frame_len)
  );

  // Output monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_sof) begin
      sof_cnt++;
      sof_pos = got_q.size();
    end
    if (rx_valid) got_q.push_back(rx_data);
    if (frame_done)
      done_q.push_back({frame_good, err_crc, err_align,
                        err_len, err_rxer, frame_len});
  end

  // Reflected (LSB-first) Ethernet CRC, one byte at a time.
  function automatic logic [31:0] crc_byte(
    input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] crc_nib(
    input logic [31:0] c, input logic [3:0] n);
    logic [31:0] r;
    r = c ^ {28'd0, n};
    for (int i = 0; i < 4; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Expected status word {good,crc,align,len,rxer,len[10:0]}.
  function automatic logic [15:0] model_status(input bit rx_err);
    logic [31:0] c;
    int          nb;
    logic [10:0] len;
    bit          e_crc, e_al, e_len;
    c = 32'hFFFFFFFF;
    foreach (nib_q[i]) c = crc_nib(c, nib_q[i]);
    nb    = nib_q.size() / 2;
    len   = (nb > 2047) ? 11'd2047 : 11'(nb);
    e_crc = (c != 32'hDEBB20E3);
    e_al  = (nib_q.size() % 2) != 0;
    e_len = (nb < 64) || (nb > 1518);
    return {!(e_crc || e_al || e_len || rx_err),
            e_crc, e_al, e_len, rx_err, len};
  endfunction

  task automatic build_frame(input int nbytes, input int flip,
                             input bit extra, input bit no5);
    logic [7:0]  pl[$];
    logic [7:0]  b;
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    nib_q.delete();
    for (int i = 0; i < nbytes; i++) begin
      b = 8'($urandom);
      if (no5 && b[3:0] == 4'h5) b[3:0] = 4'h6;
      if (no5 && b[7:4] == 4'h5) b[7:4] = 4'h6;
      pl.push_back(b);
      c = crc_byte(c, b);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) pl.push_back(c[8*k +: 8]);
    foreach (pl[i]) begin
      nib_q.push_back(pl[i][3:0]);
      nib_q.push_back(pl[i][7:4]);
    end
    if (flip >= 0) nib_q[flip] = nib_q[flip] ^ 4'h4;
    if (extra) nib_q.push_back(4'($urandom));
  endtask

  task automatic drive_frame(input logic [3:0] first_pre,
                             input int rxer_at, input int rst_at);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      rxdv = 1'b1;
      rxer = 1'b0;
      rxd  = (i == 15) ? 4'hD : ((i == 0) ? first_pre : 4'h5);
    end
    for (int i = 0; i < nib_q.size(); i++) begin
      @(posedge clk); #1;
      if (i == rst_at + 1) rst_snap = got_q.size();
      rxd   = nib_q[i];
      rxer  = (i == rxer_at);
      rst_n = (i != rst_at);
    end
    @(posedge clk); #1;
    rxdv  = 1'b0;
    rxer  = 1'b0;
    rst_n = 1'b1;
    rxd   = 4'h0;
  endtask

  task automatic clear_mon();
    got_q.delete();
    done_q.delete();
    sof_cnt = 0;
    sof_pos = -1;
  endtask

  task automatic check_frame(input string name, input bit rx_err);
    logic [15:0] exp_st;
    logic [15:0] st;
    int          nb;
    int          bad;
    exp_st = model_status(rx_err);
    nb     = nib_q.size() / 2;
    for (int k = 0; k < 30 && done_q.size() == 0; k++)
      @(negedge clk);
    n_checks++;
    if (done_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_done: no frame_done, expected status %h",
               name, exp_st);
    end else begin
      st = done_q.pop_front();
      if (st !== exp_st) begin
        n_fail++;
        $display("FAIL %s_status: got %h expected %h", name, st, exp_st);
      end
    end
    n_checks++;
    if (got_q.size() != nb) begin
      n_fail++;
      $display("FAIL %s_count: got %0d bytes expected %0d",
               name, got_q.size(), nb);
    end else begin
      bad = -1;
      for (int i = 0; i < nb; i++)
        if (bad < 0 && got_q[i] !== {nib_q[2*i+1], nib_q[2*i]}) bad = i;
      n_checks++;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL %s_bytes: byte %0d got %h expected %h", name,
                 bad, got_q[bad], {nib_q[2*bad+1], nib_q[2*bad]});
      end
    end
    n_checks++;
    if (sof_cnt !== 1 || sof_pos !== 0) begin
      n_fail++;
      $display("FAIL %s_sof: got %0d pulses at %0d expected 1 at 0",
               name, sof_cnt, sof_pos);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rxdv  = 1'b0;
    rxd   = 4'h0;
    rxer  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({rx_data, rx_valid, rx_sof, frame_done, frame_good, err_crc,
         err_align, err_len, err_rxer, frame_len} !== 28'd0) begin
      n_fail++;
      $display("FAIL reset: outputs not zero, rx_data=%h frame_len=%0d",
               rx_data, frame_len);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_good();
    clear_mon();
    build_frame(60, -1, 1'b0, 1'b0);
    drive_frame(4'h5, -1, -1);
    check_frame("good", 1'b0);
  endtask

  task automatic test_crc();
    clear_mon();
    build_frame(60, 37, 1'b0, 1'b0);
    drive_frame(4'h5, -1, -1);
    check_frame("crc", 1'b0);
  endtask

  task automatic test_length();
    clear_mon();
    build_frame(59, -1, 1'b0, 1'b0);
    drive_frame(4'h5, -1, -1);
    check_frame("short", 1'b0);
    clear_mon();
    build_frame(1515, -1, 1'b0, 1'b0);
    drive_frame(4'h5, -1, -1);
    check_frame("long", 1'b0);
    clear_mon();
    build_frame(2060, -1, 1'b0, 1'b0);
    drive_frame(4'h5, -1, -1);
    check_frame("saturate", 1'b0);
  endtask

  task automatic test_align();
    clear_mon();
    build_frame(64, -1, 1'b1, 1'b0);
    drive_frame(4'h5, -1, -1);
    check_frame("align", 1'b0);
  endtask

  task automatic test_rxer();
    clear_mon();
    build_frame(60, -1, 1'b0, 1'b0);
    drive_frame(4'h5, 51, -1);
    check_frame("rxer", 1'b1);
  endtask

  task automatic test_bad_preamble();
    clear_mon();
    build_frame(60, -1, 1'b0, 1'b0);
    drive_frame(4'hA, -1, -1);
    repeat (20) @(negedge clk);
    n_checks++;
    if (got_q.size() != 0 || done_q.size() != 0 || sof_cnt != 0) begin
      n_fail++;
      $display("FAIL bad_pre: got %0d bytes %0d done expected 0 0",
               got_q.size(), done_q.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    build_frame(60, -1, 1'b0, 1'b1);
    drive_frame(4'h5, -1, 40);
    n_checks++;
    if (got_q.size() != rst_snap || done_q.size() != 0) begin
      n_fail++;
      $display("FAIL rst_mid: got %0d bytes %0d done expected %0d 0",
               got_q.size(), done_q.size(), rst_snap);
    end
    got_q.delete();
    sof_cnt = 0;
    sof_pos = -1;
    build_frame(60, -1, 1'b0, 1'b0);
    drive_frame(4'h5, -1, -1);
    check_frame("after_rst", 1'b0);
    repeat (5) @(negedge clk);
    n_checks++;
    if (done_q.size() != 0) begin
      n_fail++;
      $display("FAIL rst_extra: got %0d extra done expected 0",
               done_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic [15:0] st;
    clear_mon();
    build_frame(70, -1, 1'b0, 1'b0);
    exp_a = model_status(1'b0);
    drive_frame(4'h5, -1, -1);
    build_frame(64, 5, 1'b0, 1'b0);
    exp_b = model_status(1'b0);
    drive_frame(4'h5, -1, -1);
    for (int k = 0; k < 30 && done_q.size() < 2; k++)
      @(negedge clk);
    n_checks++;
    if (done_q.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d done expected 2", done_q.size());
    end else begin
      st = done_q.pop_front();
      n_checks++;
      if (st !== exp_a) begin
        n_fail++;
        $display("FAIL b2b_a: got %h expected %h", st, exp_a);
      end
      st = done_q.pop_front();
      n_checks++;
      if (st !== exp_b) begin
        n_fail++;
        $display("FAIL b2b_b: got %h expected %h", st, exp_b);
      end
    end
  endtask

  task automatic test_random();
    int  nb;
    int  flip;
    int  rx_at;
    bit  extra;
    for (int t = 0; t < 6; t++) begin
      clear_mon();
      nb    = $urandom_range(46, 140);
      flip  = ($urandom % 2 == 1) ? $urandom_range(0, 2 * nb - 1) : -1;
      extra = ($urandom % 4 == 0);
      rx_at = ($urandom % 3 == 0) ? $urandom_range(0, 2 * nb - 1) : -1;
      build_frame(nb, flip, extra, 1'b0);
      drive_frame(4'h5, rx_at, -1);
      check_frame($sformatf("rand%0d", t), rx_at >= 0);
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_crc();
    test_length();
    test_align();
    test_rxer();
    test_bad_preamble();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
